// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one-outstanding reads to the
// boot RAM, and buffers returned words with their PCs in a 2-entry queue that
// is presented to decode over a valid/ready handshake. Redirects flush all
// fetched-but-unconsumed state.
module instr_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fetch_en_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] instr_rd_addr_o,
    output logic            instr_rd_en_o,
    input  logic [XLEN-1:0] instr_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] fifo_pc_q    [2];
    logic [XLEN-1:0] fifo_instr_q [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      occupancy;

    // Low address bits of the redirect target are deliberately dropped.
    logic            unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Handshake, issue decision and output muxing.
    always_comb begin
        if_valid_o      = (count_q != 2'd0) & ~redirect_valid_i;
        if_instr_o      = fifo_instr_q[rd_ptr_q];
        if_pc_o         = fifo_pc_q[rd_ptr_q];
        pop             = if_valid_o & if_ready_i;
        // Entries that will occupy the queue after this edge, counting the
        // response already in flight; keeps the 2-entry queue from overflowing.
        occupancy       = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
        // Reset gating keeps the RAM port quiet while rst_ni is held low.
        issue           = rst_ni & fetch_en_i & ~redirect_valid_i & (occupancy < 3'd2);
        push            = inflight_q & ~redirect_valid_i;
        instr_rd_en_o   = issue;
        instr_rd_addr_o = {pc_q[XLEN-1:2], 2'b00};
    end

    // Next-state logic; a redirect overrides issue, push and pop.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (redirect_valid_i) begin
            pc_d     = {redirect_pc_i[XLEN-1:2], 2'b00};
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage: the RAM response is captured the cycle after its request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= instr_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. The RAM model returns word (addr >> 2) one
// cycle after each request. Inputs change 1 ns after the rising edge and
// outputs are checked 1 ns later, so cycle numbers below count edges after
// reset release.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_en_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_rd_addr_o;
    logic        instr_rd_en_o;
    logic [31:0] instr_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    instr_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .fetch_en_i       (fetch_en_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_rd_addr_o  (instr_rd_addr_o),
        .instr_rd_en_o    (instr_rd_en_o),
        .instr_i          (instr_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Boot RAM model: word k holds value k, data valid the cycle after request.
    always @(posedge clk_i) begin
        if (instr_rd_en_o) instr_i <= instr_rd_addr_o >> 2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, if_valid_o}, 32'd1);
        chk({tag, "_pc"}, if_pc_o, pc);
        chk({tag, "_instr"}, if_instr_o, ins);
    endtask

    initial begin
        instr_i          = '0;
        rst_ni           = 1'b0;
        fetch_en_i       = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        if_ready_i       = 1'b1;
        #1;
        chk("rst_rd_en", {31'd0, instr_rd_en_o}, 32'd0);
        chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_addr", instr_rd_addr_o, 32'h0);
        cyc();
        cyc();

        // Cycle 0: release reset, first request to RESET_PC.
        rst_ni = 1'b1;
        #1;
        chk("c0_rd_en", {31'd0, instr_rd_en_o}, 32'd1);
        chk("c0_addr", instr_rd_addr_o, 32'h0);
        chk("c0_valid", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk("c1_valid", {31'd0, if_valid_o}, 32'd0);
        chk("c1_addr", instr_rd_addr_o, 32'h4);
        // Cycles 2..4: back-to-back delivery.
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            chk_head("stream", 32'(4 * k), 32'(k));
        end

        // Cycles 5..9: decode stall; queue fills and issue stops.
        cyc();
        if_ready_i = 1'b0;
        #1;
        chk_head("stall_c5", 32'hC, 32'd3);
        chk("stall_c5_rd_en", {31'd0, instr_rd_en_o}, 32'd0);
        for (int k = 6; k < 10; k++) begin
            cyc();
            if_ready_i = 1'b0;
            #1;
            chk_head("stall_hold", 32'hC, 32'd3);
            chk("stall_rd_en", {31'd0, instr_rd_en_o}, 32'd0);
        end
        // Cycles 10..12: release, sequence resumes with no skip or repeat.
        cyc();
        if_ready_i = 1'b1;
        #1;
        chk("resume_rd_en", {31'd0, instr_rd_en_o}, 32'd1);
        chk("resume_addr", instr_rd_addr_o, 32'h14);
        chk_head("resume_c10", 32'hC, 32'd3);
        for (int k = 1; k < 3; k++) begin
            cyc();
            #1;
            chk_head("resume", 32'(12 + 4 * k), 32'(3 + k));
        end

        // Cycles 13..14: fill the queue again, then redirect to 0x40.
        cyc();
        if_ready_i = 1'b0;
        #1;
        chk_head("fill_c13", 32'h18, 32'd6);
        cyc();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h40;
        #1;
        chk("redir_valid_r", {31'd0, if_valid_o}, 32'd0);
        chk("redir_rd_en_r", {31'd0, instr_rd_en_o}, 32'd0);
        cyc();
        redirect_valid_i = 1'b0;
        if_ready_i       = 1'b1;
        #1;
        chk("redir_valid_r1", {31'd0, if_valid_o}, 32'd0);
        chk("redir_rd_en_r1", {31'd0, instr_rd_en_o}, 32'd1);
        chk("redir_addr_r1", instr_rd_addr_o, 32'h40);
        cyc();
        #1;
        chk("redir_valid_r2", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk_head("redir_r3", 32'h40, 32'd16);
        cyc();
        #1;
        chk_head("redir_r4", 32'h44, 32'd17);

        // Cycle 19: misaligned redirect target 0x43 fetches from 0x40.
        cyc();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h43;
        #1;
        chk("mis_valid", {31'd0, if_valid_o}, 32'd0);
        chk("mis_rd_en", {31'd0, instr_rd_en_o}, 32'd0);
        cyc();
        redirect_valid_i = 1'b0;
        #1;
        chk("mis_addr", instr_rd_addr_o, 32'h40);
        cyc();
        #1;
        chk("mis_valid_r2", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk_head("mis_r3", 32'h40, 32'd16);

        // Cycles 23..24: back-to-back redirects, the later one wins.
        cyc();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h80;
        #1;
        chk("b2b_valid", {31'd0, if_valid_o}, 32'd0);
        cyc();
        redirect_pc_i = 32'h100;
        #1;
        chk("b2b_rd_en", {31'd0, instr_rd_en_o}, 32'd0);
        cyc();
        redirect_valid_i = 1'b0;
        #1;
        chk("b2b_addr", instr_rd_addr_o, 32'h100);
        chk("b2b_valid_r1", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk("b2b_valid_r2", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk_head("b2b_r3", 32'h100, 32'd64);

        // Cycles 28..30: fetch_en low; in-flight word still delivered.
        cyc();
        fetch_en_i = 1'b0;
        #1;
        chk_head("fen_c28", 32'h104, 32'd65);
        chk("fen_rd_en_c28", {31'd0, instr_rd_en_o}, 32'd0);
        cyc();
        #1;
        chk_head("fen_c29", 32'h108, 32'd66);
        chk("fen_rd_en_c29", {31'd0, instr_rd_en_o}, 32'd0);
        cyc();
        #1;
        chk("fen_valid_c30", {31'd0, if_valid_o}, 32'd0);
        chk("fen_rd_en_c30", {31'd0, instr_rd_en_o}, 32'd0);
        cyc();
        fetch_en_i = 1'b1;
        #1;
        chk("fen_restart_en", {31'd0, instr_rd_en_o}, 32'd1);
        chk("fen_restart_addr", instr_rd_addr_o, 32'h10C);
        cyc();
        #1;
        chk("fen_valid_c32", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk_head("fen_c33", 32'h10C, 32'd67);

        // Asynchronous reset mid-cycle: outputs drop without a clock edge.
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("arst_rd_en", {31'd0, instr_rd_en_o}, 32'd0);
        chk("arst_addr", instr_rd_addr_o, 32'h0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        #1;
        chk("post_rd_en", {31'd0, instr_rd_en_o}, 32'd1);
        chk("post_addr", instr_rd_addr_o, 32'h0);
        chk("post_valid", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk("post_valid_c1", {31'd0, if_valid_o}, 32'd0);
        cyc();
        #1;
        chk_head("post_c2", 32'h0, 32'd0);

        // PC wrap: redirect to the last word, next fetch comes from 0.
        cyc();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFC;
        #1;
        cyc();
        redirect_valid_i = 1'b0;
        #1;
        chk("wrap_addr_top", instr_rd_addr_o, 32'hFFFF_FFFC);
        cyc();
        #1;
        chk("wrap_addr_zero", instr_rd_addr_o, 32'h0);
        cyc();
        #1;
        chk_head("wrap_top", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        cyc();
        #1;
        chk_head("wrap_zero", 32'h0, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the boot RAM interface: it owns the program counter and drives the instruction-port read address and enable. It captures each instruction returned one cycle later and buffers it in a 2-entry queue tagged with its PC. Instructions are presented to decode over a valid/ready handshake. Branch/jump redirects from execute flush all fetched-but-unconsumed state.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- fetch_en  input  1  global fetch enable; low = issue no new requests
- redirect_valid  input  1  PC redirect (taken branch/jump) this cycle
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (treated as 00)
- instr_rd_addr  output  XLEN  byte address of request to boot RAM interface
- instr_rd_en  output  1  request issued this cycle
- instr  input  XLEN  RAM read data, valid exactly 1 cycle after request
- if_valid  output  1  head instruction available to decode
- if_ready  input  1  decode accepts head this cycle
- if_instr  output  XLEN  head instruction word
- if_pc  output  XLEN  byte address of if_instr

## Operation
- State: pc_q (next request address), inflight_q + inflight_pc_q (one outstanding request), 2-entry FIFO of {pc, instr} with rd/wr pointers and count_q (0..2).
- pop = if_valid & if_ready. Issue condition: fetch_en & ~redirect_valid & ((count_q - pop) + inflight_q < 2).
- instr_rd_en = issue (combinational); instr_rd_addr = {pc_q[XLEN-1:2], 2'b00} at all times.
- On issue: pc_q <= pc_q + 4 (mod 2^XLEN, wraps 0xFFFF_FFFC -> 0), inflight_q <= 1, inflight_pc_q <= pc_q. No issue: inflight_q <= 0.
- When inflight_q = 1: push {inflight_pc_q, instr} into FIFO at the clock edge. Issue rule guarantees no overflow; push and pop in the same cycle allowed (count unchanged).
- if_valid = (count_q != 0) & ~redirect_valid; if_instr/if_pc = FIFO head.
- Redirect (priority over everything): at the edge, count_q <= 0, pointers reset, inflight_q <= 0 (returning data discarded, no push), pc_q <= {redirect_pc[XLEN-1:2], 2'b00}. No issue and no pop in the redirect cycle. Back-to-back redirects: last one wins.
- fetch_en low: outstanding response still pushed, FIFO still drains; only new issue suppressed.
- Reset (async, any time, including mid-request): pc_q = RESET_PC, inflight_q = 0, count_q = 0, pointers 0. Outputs during reset: instr_rd_en 0, instr_rd_addr RESET_PC, if_valid 0; if_instr/if_pc are don't-care when if_valid is 0.

## Timing
- Fetch-to-decode latency: request issued in cycle N -> data sampled at end of N+1 -> if_valid in N+2.
- First instruction after reset release with fetch_en = 1: issue in cycle 0, if_valid in cycle 2 with if_pc = RESET_PC.
- Sustained throughput: 1 instruction/cycle while if_ready = 1.
- Decode stall (if_ready = 0): FIFO fills to 2 and issue stops. No instruction is lost or duplicated. Issue resumes in the cycle when pop = 1.
- Redirect in cycle R: issue of target in R+1; target instruction has if_valid in R+3. Nothing from before R appears after R.
- Max outstanding requests: 1. Max buffered: 2.

## Test plan
- Reset release, RESET_PC = 0, RAM word k = k, if_ready = 1 -> if_valid first in cycle 2; then if_pc 0,4,8,... with if_instr 0,1,2,... back-to-back, no gaps.
- if_ready low cycles 5-9 -> count saturates at 2 and instr_rd_en is 0 while full. On release, the sequence continues with no skipped or repeated PC.
- redirect_valid with redirect_pc = 0x40 while FIFO full and a request in flight -> if_valid low in the redirect cycle and the next cycle. The next accepted instruction has if_pc = 0x40 and instr = word 16.
- redirect_pc = 0x43 -> fetch from 0x40. Redirects in two consecutive cycles (0x80, then 0x100) -> first delivered if_pc = 0x100.
- fetch_en dropped for 3 cycles with a request in flight -> that instruction is still delivered. No instr_rd_en while low. Fetch restarts at the next sequential PC.
- rst_n asserted asynchronously mid-stream -> if_valid and instr_rd_en drop immediately. After release, fetch restarts at RESET_PC.
